// File: rtl/nn_pkg.sv
// Shared constants and types for the digit-recognition network output stages.
package nn_pkg;
  localparam int RESOLUTION  = 8;
  localparam int NUM_CLASSES = 10;

  typedef logic signed [RESOLUTION-1:0] score_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;
endpackage

// File: rtl/argmax_compare.sv
// Signed strict-greater compare and select; the incumbent wins ties so the
// lowest index survives when scanning in ascending order.
module argmax_compare #(
  parameter int W  = 8,
  parameter int IW = 4
) (
  input  logic signed [W-1:0]  i_best,
  input  logic        [IW-1:0] i_best_idx,
  input  logic signed [W-1:0]  i_cand,
  input  logic        [IW-1:0] i_cand_idx,
  output logic signed [W-1:0]  o_best,
  output logic        [IW-1:0] o_best_idx
);
  logic w_gt;

  assign w_gt       = i_cand > i_best;
  assign o_best     = w_gt ? i_cand     : i_best;
  assign o_best_idx = w_gt ? i_cand_idx : i_best_idx;
endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over a snapshot of the output-layer scores, valid/ready result.
// Optional low-confidence flag enabled by defining ARGMAX_REJECT_EN.
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int resolution  = 8,
  parameter logic signed [resolution-1:0] REJECT_THRESHOLD = '0,
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CLASSES*resolution-1:0] scores,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              digit,
  output logic signed [resolution-1:0]  max_score,
  output logic                          reject
);
  import nn_pkg::*;

  argmax_state_t                r_state;
  logic signed [resolution-1:0] r_snap [NUM_CLASSES];
  logic signed [resolution-1:0] w_scores [NUM_CLASSES];
  logic signed [resolution-1:0] r_best, r_max, w_first, w_cand, w_new_best;
  logic [IDX_W-1:0]             r_best_idx, r_idx, r_digit, w_new_idx;
  logic                         r_busy, r_valid;
  logic                         w_load_first, w_load_final;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
      assign w_scores[gi] = scores[(gi+1)*resolution-1 -: resolution];
    end
  endgenerate

  assign w_first      = w_scores[0];
  assign w_cand       = r_snap[r_idx];
  assign w_load_first = (r_state == IDLE) && start && (NUM_CLASSES == 1);
  assign w_load_final = (r_state == SCAN) && (r_idx == IDX_W'(NUM_CLASSES-1));

  argmax_compare #(.W(resolution), .IW(IDX_W)) u_cmp (
    .i_best     (r_best),
    .i_best_idx (r_best_idx),
    .i_cand     (w_cand),
    .i_cand_idx (r_idx),
    .o_best     (w_new_best),
    .o_best_idx (w_new_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_snap     <= '{default: '0};
      r_best     <= '0;
      r_best_idx <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_digit    <= '0;
      r_max      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_snap     <= w_scores;
            r_best     <= w_first;
            r_best_idx <= '0;
            r_idx      <= IDX_W'(1);
            r_busy     <= 1'b1;
            if (w_load_first) begin
              r_digit <= '0;
              r_max   <= w_first;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          r_best     <= w_new_best;
          r_best_idx <= w_new_idx;
          r_idx      <= r_idx + IDX_W'(1);
          if (w_load_final) begin
            r_digit <= w_new_idx;
            r_max   <= w_new_best;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here, even on the handshake edge
          if (out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARGMAX_REJECT_EN
  logic r_reject;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reject <= 1'b0;
    end else if (w_load_first) begin
      r_reject <= w_first < REJECT_THRESHOLD;
    end else if (w_load_final) begin
      r_reject <= w_new_best < REJECT_THRESHOLD;
    end
  end

  assign reject = r_reject;
`else
  localparam logic unused_threshold = ^REJECT_THRESHOLD;
  assign reject = 1'b0;
`endif

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign digit     = r_digit;
  assign max_score = r_max;
endmodule
